// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bundles the program-load, control and IF/ID latch signals of the
// fetch stage.
//   master modport: drives prog_we/prog_addr/prog_data, start, stall; observes latch + status.
//   slave modport : the fetch stage side (inverse directions).
`timescale 1ns / 1ps
interface instruction_fetch_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned INST_W = 16
) ();
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [INST_W-1:0] prog_data;
  logic              start;
  logic              stall;
  logic [2:0]        inst;
  logic [INST_W-1:0] inst_word;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_valid;
  logic              busy;
  logic              done;
  logic              fault;

  modport master (
    output prog_we, prog_addr, prog_data, start, stall,
    input  inst, inst_word, inst_pc, inst_valid, busy, done, fault
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, stall,
    output inst, inst_word, inst_pc, inst_valid, busy, done, fault
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage with writable instruction memory, program counter and a
// registered IF/ID latch. Walks the program one word per cycle after a start pulse, stops on
// HALT, and holds everything while stall is high.
// Ports:
//   sysclk - clock, rising edge
//   rst    - asynchronous active-high reset (memory contents are retained)
//   bus    - instruction_fetch_if.slave: program load, start/stall, latched word and status
// Build option: define IFETCH_ILLEGAL_TRAP_EN to trap opcodes 1 and 2 into a FAULT state
// (left only by rst). Without it those opcodes are fetched like any other and fault is 0.
`timescale 1ns / 1ps
module instruction_fetch #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned INST_W = 16
) (
  input  logic                sysclk,
  input  logic                rst,
  instruction_fetch_if.slave  bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
`ifdef IFETCH_ILLEGAL_TRAP_EN
  localparam logic [1:0] StFault = 2'd3;
  localparam logic [2:0] OpIll1  = 3'd1;
  localparam logic [2:0] OpIll2  = 3'd2;
`endif
  localparam logic [2:0] OpHalt  = 3'd3;

  localparam logic [ADDR_W-1:0] PcOne = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [INST_W-1:0] mem_q [Depth];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic              valid_q, valid_d;

  logic [INST_W-1:0] rd_word;
  logic [2:0]        rd_op;

  assign rd_word = mem_q[pc_q];
  assign rd_op   = rd_word[INST_W-1 -: 3];

  // Memory has no reset; writes are locked out while the program is running.
  always_ff @(posedge sysclk) begin
    if (bus.prog_we && (state_q != StRun)) begin
      mem_q[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    word_d  = word_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    case (state_q)
      StIdle, StDone: begin
        word_d  = '0;
        ipc_d   = '0;
        valid_d = 1'b0;
        if (bus.start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun: begin
        // stall freezes PC, latch and state, so HALT/illegal wait until it drops.
        if (!bus.stall) begin
          if (rd_op == OpHalt) begin
            word_d  = '0;
            ipc_d   = '0;
            valid_d = 1'b0;
            state_d = StDone;
          end
`ifdef IFETCH_ILLEGAL_TRAP_EN
          else if ((rd_op == OpIll1) || (rd_op == OpIll2)) begin
            word_d  = '0;
            ipc_d   = '0;
            valid_d = 1'b0;
            state_d = StFault;
          end
`endif
          else begin
            word_d  = rd_word;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PcOne;  // natural wrap at 2^ADDR_W
          end
        end
      end
      default: begin
        // FAULT: sticky until rst, latch shows a bubble.
        word_d  = '0;
        ipc_d   = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      word_q  <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      word_q  <= word_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign bus.inst       = word_q[INST_W-1 -: 3];
  assign bus.inst_word  = word_q;
  assign bus.inst_pc    = ipc_q;
  assign bus.inst_valid = valid_q;
  assign bus.busy       = (state_q == StRun);
  assign bus.done       = (state_q == StDone);
`ifdef IFETCH_ILLEGAL_TRAP_EN
  assign bus.fault      = (state_q == StFault);
`else
  assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch: program load, straight-line run, stall hold,
// asynchronous reset mid-run, write lockout in RUN, illegal-opcode handling, PC wrap.
`timescale 1ns / 1ps
module tb_instruction_fetch;

  logic sysclk = 1'b0;
  logic rst    = 1'b1;

  instruction_fetch_if #(.ADDR_W(5), .INST_W(16)) bus ();

  instruction_fetch #(.ADDR_W(5), .INST_W(16)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Step past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk_latch(input string tag, input logic [2:0] op, input logic [4:0] pc,
                           input logic v);
    chk({tag, ".inst"}, {29'd0, bus.inst}, {29'd0, op});
    chk({tag, ".pc"}, {27'd0, bus.inst_pc}, {27'd0, pc});
    chk({tag, ".valid"}, {31'd0, bus.inst_valid}, {31'd0, v});
  endtask

  task automatic load(input logic [4:0] a, input logic [15:0] d);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = d;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_w;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.stall = 1'b0;

    // Reset values
    tick(); tick();
    chk_latch("rst", 3'd0, 5'd0, 1'b0);
    chk("rst.word", {16'd0, bus.inst_word}, 32'd0);
    chk("rst.busy", {31'd0, bus.busy}, 32'd0);
    chk("rst.done", {31'd0, bus.done}, 32'd0);
    chk("rst.fault", {31'd0, bus.fault}, 32'd0);
    #2 rst = 1'b0;

    // Program: ADD ADDI SW LW SLL HALT
    load(5'd0, {3'd0, 13'h0010});
    load(5'd1, {3'd4, 13'h0011});
    load(5'd2, {3'd5, 13'h0012});
    load(5'd3, {3'd6, 13'h0013});
    load(5'd4, {3'd7, 13'h0014});
    load(5'd5, {3'd3, 13'h0015});

    // Straight run
    pulse_start();
    chk("run.busy", {31'd0, bus.busy}, 32'd1);
    chk("run.first_bubble", {31'd0, bus.inst_valid}, 32'd0);
    tick(); chk_latch("run0", 3'd0, 5'd0, 1'b1);
    chk("run0.word", {16'd0, bus.inst_word}, 32'h0010);
    tick(); chk_latch("run1", 3'd4, 5'd1, 1'b1);
    tick(); chk_latch("run2", 3'd5, 5'd2, 1'b1);
    tick(); chk_latch("run3", 3'd6, 5'd3, 1'b1);
    tick(); chk_latch("run4", 3'd7, 5'd4, 1'b1);
    chk("run4.word", {16'd0, bus.inst_word}, 32'hE014);
    tick(); chk_latch("halt", 3'd0, 5'd0, 1'b0);
    chk("halt.done", {31'd0, bus.done}, 32'd1);
    chk("halt.busy", {31'd0, bus.busy}, 32'd0);

    // Stall for 3 cycles while inst_pc = 2
    pulse_start();
    chk("restart.busy", {31'd0, bus.busy}, 32'd1);
    chk("restart.done", {31'd0, bus.done}, 32'd0);
    tick(); tick(); tick();
    chk_latch("st_pre", 3'd5, 5'd2, 1'b1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_latch("st_hold", 3'd5, 5'd2, 1'b1);
    end
    bus.stall = 1'b0;
    tick(); chk_latch("st_res3", 3'd6, 5'd3, 1'b1);
    tick(); chk_latch("st_res4", 3'd7, 5'd4, 1'b1);
    tick(); chk("st.done", {31'd0, bus.done}, 32'd1);

    // Asynchronous reset while inst_pc = 3, no clock edge in between
    pulse_start();
    tick(); tick(); tick(); tick();
    chk_latch("ar_pre", 3'd6, 5'd3, 1'b1);
    rst = 1'b1;
    #2;
    chk_latch("ar", 3'd0, 5'd0, 1'b0);
    chk("ar.word", {16'd0, bus.inst_word}, 32'd0);
    chk("ar.busy", {31'd0, bus.busy}, 32'd0);
    #2 rst = 1'b0;
    tick();
    pulse_start();
    tick(); chk_latch("ar_re0", 3'd0, 5'd0, 1'b1);
    tick(); chk_latch("ar_re1", 3'd4, 5'd1, 1'b1);

    // Write attempt during RUN must be ignored
    bus.prog_we = 1'b1; bus.prog_addr = 5'd4; bus.prog_data = {3'd0, 13'h0};
    tick(); chk_latch("we_run2", 3'd5, 5'd2, 1'b1);
    bus.prog_we = 1'b0;
    tick(); chk_latch("we_run3", 3'd6, 5'd3, 1'b1);
    tick(); chk_latch("we_run4", 3'd7, 5'd4, 1'b1);
    tick(); chk("we_run.done", {31'd0, bus.done}, 32'd1);

    // Illegal opcode 2 at address 1
    load(5'd1, {3'd2, 13'h0001});
    pulse_start();
    tick(); chk_latch("ill0", 3'd0, 5'd0, 1'b1);
    tick();
`ifdef IFETCH_ILLEGAL_TRAP_EN
    chk("ill.fault", {31'd0, bus.fault}, 32'd1);
    chk("ill.valid", {31'd0, bus.inst_valid}, 32'd0);
    pulse_start();
    chk("ill.start_ign.fault", {31'd0, bus.fault}, 32'd1);
    chk("ill.start_ign.busy", {31'd0, bus.busy}, 32'd0);
    tick();
    chk("ill.start_ign.valid", {31'd0, bus.inst_valid}, 32'd0);
    rst = 1'b1;
    #2 rst = 1'b0;
    chk("ill.rst.fault", {31'd0, bus.fault}, 32'd0);
`else
    chk_latch("ill1", 3'd2, 5'd1, 1'b1);
    chk("ill.fault", {31'd0, bus.fault}, 32'd0);
    tick(); chk_latch("ill2", 3'd5, 5'd2, 1'b1);
    tick(); tick(); tick();
    chk("ill.done", {31'd0, bus.done}, 32'd1);
`endif

    // Fill memory with ADD (no HALT); start with a same-cycle write to address 0
    for (int i = 0; i < 32; i++) begin
      load(i[4:0], {3'd0, 8'd0, i[4:0]});
    end
    bus.prog_we = 1'b1; bus.prog_addr = 5'd0; bus.prog_data = {3'd7, 13'h0};
    pulse_start();
    bus.prog_we = 1'b0;
    chk("wrap.busy0", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_w = (i == 0) ? {3'd7, 13'h0} : {3'd0, 8'd0, i[4:0]};
      chk("wrap.pc", {27'd0, bus.inst_pc}, i);
      chk("wrap.word", {16'd0, bus.inst_word}, {16'd0, exp_w});
    end
    tick(); chk_latch("wrap_to0", 3'd7, 5'd0, 1'b1);
    tick(); chk_latch("wrap_to1", 3'd0, 5'd1, 1'b1);
    chk("wrap.busy", {31'd0, bus.busy}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the five-opcode pipeline. It holds a writable instruction memory and a program counter, and walks the program one word per cycle. It presents each word through a registered IF/ID latch to `instructiondecode`, which samples `inst` on the next `sysclk` edge. The stage supports program loading, start/halt control, a stall hold from downstream, and an optional illegal-opcode trap.

## Interface
- `ADDR_W`, 5: PC and instruction-memory address width. Memory depth is 2^ADDR_W words.
- `INST_W`, 16: instruction word width. Bits [INST_W-1:INST_W-3] are the opcode.

- `sysclk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `prog_we`  in  1  instruction-memory write strobe.
- `prog_addr`  in  ADDR_W  write address.
- `prog_data`  in  INST_W  write data.
- `start`  in  1  single-cycle pulse that begins execution at PC 0.
- `stall`  in  1  downstream hold. Freezes the PC and the IF/ID latch.
- `inst`  out  3  latched opcode, feeds decode `inst`.
- `inst_word`  out  INST_W  latched full instruction word.
- `inst_pc`  out  ADDR_W  address of the latched word.
- `inst_valid`  out  1  latch holds a real instruction. 0 means bubble.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `fault`  out  1  state is FAULT. Trap build only; tied to 0 otherwise.

## Operation
- Opcodes: ADD=0, ADDI=4, SW=5, LW=6, SLL=7, HALT=3. Opcodes 1 and 2 are illegal.
- States:
  - IDLE → RUN on `start`. PC is set to 0.
  - RUN → DONE when the word read at PC has opcode HALT.
  - RUN → FAULT when the word read at PC has an illegal opcode (trap build only).
  - DONE → RUN on `start`. PC is set to 0.
  - FAULT → IDLE only via `rst`.
- In RUN with `stall`=0, each cycle:
  - Read mem[PC] combinationally.
  - Legal non-HALT word: latch it, set `inst_valid`=1, `inst_pc`=PC, PC=PC+1 mod 2^ADDR_W. PC wraps from 2^ADDR_W-1 to 0 and execution continues.
  - HALT: latch a bubble (`inst_valid`=0, `inst`=0). PC is unchanged. Enter DONE.
- In RUN with `stall`=1: PC, the latch and the state all hold. A HALT or illegal word at PC is not acted on until `stall` falls.
- Outside RUN: the latch shows a bubble and `stall` is ignored.
- `prog_we` writes memory only in IDLE, DONE or FAULT. In RUN it is ignored.
- `start` in RUN or FAULT is ignored.
- `start` and `prog_we` in the same cycle (IDLE or DONE): the write commits, and the first fetch, one cycle later, sees the new data.
- Memory contents are not cleared by `rst`.

## Timing
- Reset values: PC=0, state IDLE, `inst`=0, `inst_word`=0, `inst_pc`=0, `inst_valid`=0, `busy`=0, `done`=0, `fault`=0.
- `rst` asserted mid-RUN clears everything above immediately, with no clock edge needed. Memory is retained.
- `start` sampled at edge N:
  - `busy`=1 after edge N.
  - First word latched at edge N+1 (`inst_valid`=1, `inst_pc`=0).
- Steady throughput is one word per cycle. Fetch-to-latch latency is 1 cycle.
- `stall` sampled high at edge K: outputs after K equal outputs before K.
- HALT at PC p sampled at edge K: `done`=1 and `inst_valid`=0 after K.
- All outputs are registered. None is combinational from an input.

## Configuration
- Macro `IFETCH_ILLEGAL_TRAP_EN`.
- Defined: opcode 1 or 2 at PC in RUN with `stall`=0 latches a bubble, freezes PC, enters FAULT and sets `fault`=1.
- Undefined: opcodes 1 and 2 are treated as ordinary instructions and latched with `inst_valid`=1. `fault` is constant 0 and the FAULT state does not exist.

## Test plan
- Load ADD, ADDI, SW, LW, SLL, HALT at addresses 0–5, then pulse `start` → `inst` = 0, 4, 5, 6, 7 on consecutive cycles with `inst_pc` = 0..4, then `inst_valid`=0 and `done`=1.
- Run the same program with `stall` held high for 3 cycles while `inst_pc`=2 → `inst`=5 and `inst_pc`=2 hold for 3 cycles, then the sequence resumes with 6 at PC 3.
- Fill all 32 words with ADD, with no HALT → `inst_pc` counts 31 then 0 then 1, and `busy` stays 1.
- Assert `rst` while `inst_pc`=3 → all outputs go to reset values before the next edge. A subsequent `start` refetches from PC 0 using the preserved program.
- Pulse `prog_we` in RUN with `prog_addr`=4, `prog_data` opcode 0 → memory is unchanged and PC 4 still yields its original opcode.
- Place opcode 2 at address 1:
  - With `IFETCH_ILLEGAL_TRAP_EN` defined → one valid word at PC 0, then `fault`=1, `inst_valid`=0, and `start` is ignored.
  - Without the macro → `inst`=2 at PC 1 and execution continues.
